avmm_ddr_channel_arbiter: RTL and testbench

AVMM_DDR_CHANNEL_ARBITER -- requirements
Module: avmm_ddr_channel_arbiter

---
 rtl/avmm_arb_pkg.sv | 21 ++
 rtl/avmm_arb_rsp_fifo.sv | 58 +++++
 rtl/avmm_ddr_channel_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_avmm_ddr_channel_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared types for the AVMM DDR channel arbiter: FSM states, counter width,
// and the read-response bookkeeping entry.
package avmm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WR_BURST = 2'd2
  } arb_state_e;

  localparam int CNT_W       = 32;
  // Entry fields are sized for the largest legal config (8 channels, BURST_W <= 8)
  localparam int RSP_CH_W    = 3;
  localparam int RSP_BEATS_W = 8;

  typedef struct packed {
    logic [RSP_CH_W-1:0]    ch;
    logic [RSP_BEATS_W-1:0] beats;
  } rsp_entry_t;

endpackage

// File: rtl/avmm_arb_rsp_fifo.sv
// Outstanding-read FIFO: one entry per accepted read command, popped when the
// last beat of that command's read data returns.
module avmm_arb_rsp_fifo
  import avmm_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  rsp_entry_t wdata_i,
  input  logic       pop_i,
  output rsp_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1 = AW + 1;

  rsp_entry_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == AW1'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot the same cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + AW1'(1);
      2'b01:   cnt_d = cnt_q - AW1'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/avmm_ddr_channel_arbiter.sv
// Round-robin arbiter of NUM_CH Avalon-MM DMA channels onto one DDR port.
// Define AVMM_ARB_STATS_EN to build the per-channel grant counters.
module avmm_ddr_channel_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 32,
  parameter int BURST_W   = 3,
  parameter int RSP_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_CH-1:0]                   s_read,
  input  logic [NUM_CH-1:0]                   s_write,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]       s_address,
  input  logic [NUM_CH-1:0][BURST_W-1:0]      s_burstcount,
  input  logic [NUM_CH-1:0][DATA_W-1:0]       s_writedata,
  input  logic [NUM_CH-1:0][DATA_W/8-1:0]     s_byteenable,
  output logic [NUM_CH-1:0]                   s_waitrequest,
  output logic [DATA_W-1:0]                   s_readdata,
  output logic [NUM_CH-1:0]                   s_readdatavalid,
  output logic                                m_read,
  output logic                                m_write,
  output logic [ADDR_W-1:0]                   m_address,
  output logic [BURST_W-1:0]                  m_burstcount,
  output logic [DATA_W-1:0]                   m_writedata,
  output logic [DATA_W/8-1:0]                 m_byteenable,
  output logic                                m_debugaccess,
  input  logic                                m_waitrequest,
  input  logic [DATA_W-1:0]                   m_readdata,
  input  logic                                m_readdatavalid,
  output logic                                err_unexpected_rsp,
  output logic [NUM_CH-1:0][CNT_W-1:0]        stat_grant_cnt
);

  localparam int CH_W = $clog2(NUM_CH);

  arb_state_e         state_q, state_d;
  logic [CH_W-1:0]    g_q, g_d, rr_q, rr_d, rr_next, pick;
  logic [BURST_W-1:0] beats_q, beats_d, bc_eff;
  logic               err_q, err_d;
  logic [RSP_BEATS_W-1:0] hd_cnt_q, hd_cnt_d;

  logic [NUM_CH-1:0]  req;
  logic               found;
  int                 idx;
  logic               rd_block, push, pop, rdv_hit, last_beat;
  logic               fifo_full, fifo_empty;
  rsp_entry_t         push_entry, head;

  assign req     = s_read | s_write;
  assign rr_next = (g_q == CH_W'(NUM_CH - 1)) ? '0 : g_q + CH_W'(1);
  assign bc_eff  = (s_burstcount[g_q] == '0) ? BURST_W'(1) : s_burstcount[g_q];

  // First requester at or after rr_q, wrapping around
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  // Command path mux: only the granted channel ever sees waitrequest low
  assign m_address     = s_address[g_q];
  assign m_burstcount  = bc_eff;
  assign m_writedata   = s_writedata[g_q];
  assign m_byteenable  = s_byteenable[g_q];
  assign m_debugaccess = 1'b0;
  assign rd_block      = s_read[g_q] & fifo_full;

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    rr_d          = rr_q;
    beats_d       = beats_q;
    m_read        = 1'b0;
    m_write       = 1'b0;
    s_waitrequest = '1;
    push          = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_waitrequest[g_q] = m_waitrequest | rd_block;
        m_read  = s_read[g_q] & ~rd_block;
        m_write = s_write[g_q] & ~s_read[g_q];
        if (m_read && !m_waitrequest) begin
          push    = 1'b1;
          state_d = IDLE;
          rr_d    = rr_next;
        end else if (m_write && !m_waitrequest) begin
          beats_d = bc_eff - BURST_W'(1);
          if (bc_eff == BURST_W'(1)) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end else begin
            state_d = WR_BURST;
          end
        end
      end
      WR_BURST: begin
        s_waitrequest[g_q] = m_waitrequest | rd_block;
        m_write = s_write[g_q];
        if (m_write && !m_waitrequest) begin
          beats_d = beats_q - BURST_W'(1);
          if (beats_q == BURST_W'(1)) begin
            state_d = IDLE;
            rr_d    = rr_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_entry       = '0;
    push_entry.ch    = RSP_CH_W'(g_q);
    push_entry.beats = RSP_BEATS_W'(bc_eff);
  end

  avmm_arb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Read data is routed to whichever channel owns the oldest outstanding read
  assign s_readdata = m_readdata;
  assign rdv_hit    = m_readdatavalid & ~fifo_empty;
  assign last_beat  = (hd_cnt_q + RSP_BEATS_W'(1)) == head.beats;
  assign pop        = rdv_hit & last_beat;
  assign err_d      = err_q | (m_readdatavalid & fifo_empty);
  assign err_unexpected_rsp = err_q;

  always_comb begin
    s_readdatavalid = '0;
    if (rdv_hit) s_readdatavalid[head.ch[CH_W-1:0]] = 1'b1;
    hd_cnt_d = hd_cnt_q;
    if (rdv_hit) hd_cnt_d = last_beat ? '0 : hd_cnt_q + RSP_BEATS_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      g_q      <= '0;
      rr_q     <= '0;
      beats_q  <= '0;
      err_q    <= 1'b0;
      hd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      rr_q     <= rr_d;
      beats_q  <= beats_d;
      err_q    <= err_d;
      hd_cnt_q <= hd_cnt_d;
    end
  end

`ifdef AVMM_ARB_STATS_EN
  logic                         accept_cmd;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

  // A read, or the first beat of a write burst, counts as one grant
  assign accept_cmd = (state_q == GRANT) & (m_read | m_write) & ~m_waitrequest;
  assign stat_grant_cnt = cnt_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        cnt_q[c] <= '0;
      else if (accept_cmd && g_q == CH_W'(c))
        cnt_q[c] <= cnt_q[c] + CNT_W'(1);
    end
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_avmm_ddr_channel_arbiter.sv
// Directed, table-driven bench for avmm_ddr_channel_arbiter (default params).
module tb_avmm_ddr_channel_arbiter;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [3:0]            s_read, s_write;
  logic [3:0][31:0]      s_address;
  logic [3:0][2:0]       s_burstcount;
  logic [3:0][511:0]     s_writedata;
  logic [3:0][63:0]      s_byteenable;
  logic [3:0]            s_waitrequest;
  logic [511:0]          s_readdata;
  logic [3:0]            s_readdatavalid;
  logic                  m_read, m_write;
  logic [31:0]           m_address;
  logic [2:0]            m_burstcount;
  logic [511:0]          m_writedata;
  logic [63:0]           m_byteenable;
  logic                  m_debugaccess;
  logic                  m_waitrequest;
  logic [511:0]          m_readdata;
  logic                  m_readdatavalid;
  logic                  err_unexpected_rsp;
  logic [3:0][31:0]      stat_grant_cnt;

  int vecs = 0;
  int miscompares = 0;

  avmm_ddr_channel_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_debugaccess(m_debugaccess),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .err_unexpected_rsp(err_unexpected_rsp), .stat_grant_cnt(stat_grant_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rd, wr;
    logic [2:0] bc;
    logic       mw, mv;
    logic       e_rd, e_wr;
    int         e_ch;
    logic [3:0] e_sw, e_rv;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] addr_of(input int c);
    return 32'(32'h1000 * (c + 1));
  endfunction

  function automatic logic [511:0] wd_of(input int c);
    logic [31:0] w;
    w = 32'(32'hD000_0000 + c);
    return {16{w}};
  endfunction

  task automatic add(input logic [3:0] rd, input logic [3:0] wr, input logic [2:0] bc,
                     input logic mw, input logic mv, input logic erd, input logic ewr,
                     input int ech, input logic [3:0] esw, input logic [3:0] erv,
                     input logic eerr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.bc = bc; v.mw = mw; v.mv = mv;
    v.e_rd = erd; v.e_wr = ewr; v.e_ch = ech; v.e_sw = esw; v.e_rv = erv; v.e_err = eerr;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_bc(input logic [2:0] bc);
    for (int c = 0; c < 4; c++) s_burstcount[c] = bc;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Hold s_read on one channel until the arbiter accepts it (bounded)
  task automatic issue_read(input int ch);
    bit acc = 1'b0;
    s_read[ch] = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1 acc = !s_waitrequest[ch];
      @(negedge clk);
    end
    s_read[ch] = 1'b0;
    check($sformatf("accept_ch%0d", ch), 64'(acc), 64'(1));
  endtask

  initial begin
    reset_n = 1'b0;
    s_read = '0; s_write = '0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
    m_readdata = {16{32'hCAFE_F00D}};
    set_bc(3'd1);
    for (int c = 0; c < 4; c++) begin
      s_address[c]    = addr_of(c);
      s_writedata[c]  = wd_of(c);
      s_byteenable[c] = '1;
    end

    // Reset state
    #1;
    check("reset_state",
          64'({s_waitrequest, m_read, m_write, s_readdatavalid, err_unexpected_rsp, m_debugaccess}),
          64'({4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0}));
    check("reset_stats", 64'(stat_grant_cnt[0] | stat_grant_cnt[1] | stat_grant_cnt[2] | stat_grant_cnt[3]), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    //  rd      wr      bc   mw mv  erd ewr ech  esw      erv      err
    // simultaneous ch0/ch2 reads, then ch0/ch3 proves rr_ptr = 3
    add(4'b0101, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0101, 4'b0000, 3'd1, 0, 0, 1, 0, 0, 4'b1110, 4'b0000, 0);
    add(4'b0100, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0100, 4'b0000, 3'd1, 0, 0, 1, 0, 2, 4'b1011, 4'b0000, 0);
    add(4'b1001, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b1001, 4'b0000, 3'd1, 0, 0, 1, 0, 3, 4'b0111, 4'b0000, 0);
    add(4'b0001, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0001, 4'b0000, 3'd1, 0, 0, 1, 0, 0, 4'b1110, 4'b0000, 0);
    // drain in order 0,2,3,0
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b0001, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b0100, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b1000, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b0001, 0);
    // ch1 4-beat write (one stalled cycle) locks out ch0's read
    add(4'b0001, 4'b0010, 3'd4, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0001, 4'b0010, 3'd4, 0, 0, 0, 1, 1, 4'b1101, 4'b0000, 0);
    add(4'b0001, 4'b0010, 3'd4, 1, 0, 0, 1, 1, 4'b1111, 4'b0000, 0);
    add(4'b0001, 4'b0010, 3'd4, 0, 0, 0, 1, 1, 4'b1101, 4'b0000, 0);
    add(4'b0001, 4'b0010, 3'd4, 0, 0, 0, 1, 1, 4'b1101, 4'b0000, 0);
    add(4'b0001, 4'b0010, 3'd4, 0, 0, 0, 1, 1, 4'b1101, 4'b0000, 0);
    add(4'b0001, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0001, 4'b0000, 3'd1, 0, 0, 1, 0, 0, 4'b1110, 4'b0000, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b0001, 0);
    // ch3 burst 2 then ch0 burst 1 -> rdv 1000,1000,0001
    add(4'b1000, 4'b0000, 3'd2, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b1000, 4'b0000, 3'd2, 0, 0, 1, 0, 3, 4'b0111, 4'b0000, 0);
    add(4'b0001, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0001, 4'b0000, 3'd1, 0, 0, 1, 0, 0, 4'b1110, 4'b0000, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b1000, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b1000, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b0001, 0);
    // unexpected response: dropped, sticky error from next cycle on
    add(4'b0000, 4'b0000, 3'd1, 0, 1, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(4'b0000, 4'b0000, 3'd1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 1);
    // burstcount 0 read on ch1 with one waitrequest cycle -> single beat
    add(4'b0010, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 1);
    add(4'b0010, 4'b0000, 3'd0, 1, 0, 1, 0, 1, 4'b1111, 4'b0000, 1);
    add(4'b0010, 4'b0000, 3'd0, 0, 0, 1, 0, 1, 4'b1101, 4'b0000, 1);
    add(4'b0000, 4'b0000, 3'd0, 0, 1, 0, 0, 0, 4'b1111, 4'b0010, 1);
    add(4'b0000, 4'b0000, 3'd0, 0, 1, 0, 0, 0, 4'b1111, 4'b0000, 1);
    // burstcount 0 write on ch2 -> single beat, back to IDLE
    add(4'b0000, 4'b0100, 3'd0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 1);
    add(4'b0000, 4'b0100, 3'd0, 0, 0, 0, 1, 2, 4'b1011, 4'b0000, 1);
    add(4'b0000, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 1);

    foreach (tbl[i]) begin
      logic [2:0] bce;
      logic       pay;
      @(negedge clk);
      s_read = tbl[i].rd; s_write = tbl[i].wr; set_bc(tbl[i].bc);
      m_waitrequest = tbl[i].mw; m_readdatavalid = tbl[i].mv;
      #1;
      bce = (tbl[i].bc == 3'd0) ? 3'd1 : tbl[i].bc;
      pay = 1'b1;
      if (tbl[i].e_rd || tbl[i].e_wr)
        pay = (m_address == addr_of(tbl[i].e_ch)) && (m_burstcount == bce);
      if (tbl[i].e_wr)
        pay = pay && (m_writedata == wd_of(tbl[i].e_ch)) && (m_byteenable == '1);
      check($sformatf("vec%0d", i),
            64'({m_read, m_write, s_waitrequest, s_readdatavalid, err_unexpected_rsp, pay}),
            64'({tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_sw, tbl[i].e_rv, tbl[i].e_err, 1'b1}));
    end

    @(negedge clk);
    s_read = '0; s_write = '0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0; set_bc(3'd1);
    pulse_reset();
    #1 check("err_cleared", 64'(err_unexpected_rsp), 64'(0));
    @(negedge clk);

    // Fill all 16 response slots, 17th read must stall until one beat returns
    for (int n = 0; n < 16; n++) issue_read(0);
    s_read[0] = 1'b1;
    #1;
    @(negedge clk);
    #1 check("rd17_stall", 64'({s_waitrequest[0], m_read}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    m_readdatavalid = 1'b1;
    #1 check("rd17_pop_cycle", 64'({s_waitrequest[0], m_read, s_readdatavalid}),
             64'({1'b1, 1'b0, 4'b0001}));
    @(negedge clk);
    m_readdatavalid = 1'b0;
    #1 check("rd17_unblock", 64'({s_waitrequest[0], m_read}), 64'({1'b0, 1'b1}));
    @(negedge clk);
    s_read[0] = 1'b0;

    // ch1 write burst, reset pulsed in the middle of it
    s_write[1] = 1'b1; s_burstcount[1] = 3'd4;
    #1;
    @(negedge clk);
    #1 check("wr_grant", 64'({m_write, m_address}), 64'({1'b1, addr_of(1)}));
    @(negedge clk);
    #1 check("wr_burst", 64'({m_write, s_waitrequest}), 64'({1'b1, 4'b1101}));
    m_readdatavalid = 1'b1;
    reset_n = 1'b0;
    #1 check("rst_async",
             64'({s_waitrequest, m_read, m_write, s_readdatavalid, err_unexpected_rsp}),
             64'({4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0}));
    check("rst_stats", 64'(stat_grant_cnt[0] | stat_grant_cnt[1] | stat_grant_cnt[2] | stat_grant_cnt[3]), 64'(0));
    m_readdatavalid = 1'b0; s_write = '0; set_bc(3'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    s_read = 4'b1111;
    #1;
    @(negedge clk);
    #1 check("rr_after_rst", 64'({m_read, m_address}), 64'({1'b1, addr_of(0)}));
    @(negedge clk);
    s_read = '0;
    // Only the read just issued is outstanding; old ones are gone
    m_readdatavalid = 1'b1;
    #1 check("post_rst_rdv1", 64'(s_readdatavalid), 64'(4'b0001));
    @(negedge clk);
    #1 check("post_rst_rdv2", 64'({s_readdatavalid, err_unexpected_rsp}), 64'({4'b0000, 1'b0}));
    @(negedge clk);
    m_readdatavalid = 1'b0;
    #1 check("post_rst_err", 64'(err_unexpected_rsp), 64'(1));

    // Grant statistics
    pulse_reset();
    @(negedge clk);
    for (int n = 0; n < 5; n++) issue_read(2);
    #1;
`ifdef AVMM_ARB_STATS_EN
    check("stat_ch2", 64'(stat_grant_cnt[2]), 64'(5));
    check("stat_others", 64'(stat_grant_cnt[0] | stat_grant_cnt[1] | stat_grant_cnt[3]), 64'(0));
`else
    check("stat_off", 64'(stat_grant_cnt[0] | stat_grant_cnt[1] | stat_grant_cnt[2] | stat_grant_cnt[3]), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
